// File: rtl/button_debouncer_if.sv
// Button debouncer signal bundle: the synchronized raw level in, the clean level
// and press/release pulses out.
interface button_debouncer_if;
    logic value_i;
    logic level_o;
    logic rise_o;
    logic fall_o;

    modport slave  (input  value_i, output level_o, rise_o, fall_o);
    modport master (output value_i, input  level_o, rise_o, fall_o);
endinterface

// File: rtl/button_debouncer.sv
// Debounces one synchronized button level into a clean level plus one-cycle
// press/release pulses. Optional auto-repeat of the press pulse: BUTTON_DEBOUNCER_AUTOREPEAT_EN.
module button_debouncer_checker #(
    parameter bit PARAMS_OK = 1'b1
) (
    input logic clock_i,
    input logic reset_i,
    input logic level,
    input logic rise,
    input logic fall
);
    a_params_legal: assert property (@(posedge clock_i) PARAMS_OK);
    a_pulses_exclusive: assert property (@(posedge clock_i) disable iff (reset_i) !(rise && fall));
    a_rise_level: assert property (@(posedge clock_i) disable iff (reset_i) rise |-> level);
    a_fall_level: assert property (@(posedge clock_i) disable iff (reset_i) fall |-> !level);
endmodule

module button_debouncer #(
    parameter int unsigned STABLE_CYCLES = 1000000,
    parameter int unsigned REPEAT_DELAY  = 50000000,
    parameter int unsigned REPEAT_PERIOD = 10000000
) (
    input logic                clock_i,
    input logic                reset_i,
    button_debouncer_if.slave  btn
);
    localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 32'd1);
    localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 32'd1);
    localparam bit PARAMS_OK = (STABLE_CYCLES >= 32'd2) && (REPEAT_DELAY >= 32'd1)
                               && (REPEAT_PERIOD >= 32'd1);

    typedef enum logic [1:0] {
        IDLE_LOW     = 2'd0,
        CONFIRM_HIGH = 2'd1,
        HELD_HIGH    = 2'd2,
        CONFIRM_LOW  = 2'd3
    } state_t;

    state_t           state_r;
    state_t           state_s;
    logic [CNT_W-1:0] count_r;
    logic [CNT_W-1:0] count_s;
    logic             level_r;
    logic             level_s;
    logic             rise_r;
    logic             rise_s;
    logic             fall_r;
    logic             fall_s;
    logic             press_s;
    logic             value_s;

    assign value_s     = btn.value_i;
    assign btn.level_o = level_r;
    assign btn.rise_o  = rise_r;
    assign btn.fall_o  = fall_r;

    // Next-state logic: count consecutive samples that differ from the accepted level
    always_comb begin
        state_s = state_r;
        count_s = count_r;
        level_s = level_r;
        press_s = 1'b0;
        fall_s  = 1'b0;
        case (state_r)
            IDLE_LOW: begin
                if (value_s) begin
                    state_s = CONFIRM_HIGH;
                    count_s = CNT_W'(1);
                end else begin
                    count_s = {CNT_W{1'b0}};
                end
            end
            CONFIRM_HIGH: begin
                if (!value_s) begin
                    state_s = IDLE_LOW;
                    count_s = {CNT_W{1'b0}};
                end else if (count_r == STABLE_LAST) begin
                    state_s = HELD_HIGH;
                    level_s = 1'b1;
                    press_s = 1'b1;
                    count_s = {CNT_W{1'b0}};
                end else begin
                    count_s = count_r + CNT_W'(1);
                end
            end
            HELD_HIGH: begin
                if (!value_s) begin
                    state_s = CONFIRM_LOW;
                    count_s = CNT_W'(1);
                end else begin
                    count_s = {CNT_W{1'b0}};
                end
            end
            CONFIRM_LOW: begin
                if (value_s) begin
                    state_s = HELD_HIGH;
                    count_s = {CNT_W{1'b0}};
                end else if (count_r == STABLE_LAST) begin
                    state_s = IDLE_LOW;
                    level_s = 1'b0;
                    fall_s  = 1'b1;
                    count_s = {CNT_W{1'b0}};
                end else begin
                    count_s = count_r + CNT_W'(1);
                end
            end
            default: begin
                state_s = IDLE_LOW;
                count_s = {CNT_W{1'b0}};
                level_s = 1'b0;
            end
        endcase
    end

`ifdef BUTTON_DEBOUNCER_AUTOREPEAT_EN
    localparam int unsigned REPEAT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int unsigned TMR_W = $clog2(REPEAT_MAX + 32'd1);
    localparam logic [TMR_W-1:0] DELAY_LAST  = TMR_W'(REPEAT_DELAY - 32'd1);
    localparam logic [TMR_W-1:0] PERIOD_LAST = TMR_W'(REPEAT_PERIOD - 32'd1);

    logic [TMR_W-1:0] timer_r;
    logic [TMR_W-1:0] timer_s;
    logic             repeating_r;
    logic             repeating_s;
    logic             repeat_pulse_s;

    // Repeat timer ticks on every held-high sample; low samples during a glitch freeze it
    always_comb begin
        timer_s        = timer_r;
        repeating_s    = repeating_r;
        repeat_pulse_s = 1'b0;
        if (press_s || fall_s) begin
            timer_s     = {TMR_W{1'b0}};
            repeating_s = 1'b0;
        end else if (value_s && ((state_r == HELD_HIGH) || (state_r == CONFIRM_LOW))) begin
            if (!repeating_r && (timer_r == DELAY_LAST)) begin
                repeat_pulse_s = 1'b1;
                repeating_s    = 1'b1;
                timer_s        = {TMR_W{1'b0}};
            end else if (repeating_r && (timer_r == PERIOD_LAST)) begin
                repeat_pulse_s = 1'b1;
                timer_s        = {TMR_W{1'b0}};
            end else begin
                timer_s = timer_r + TMR_W'(1);
            end
        end else begin
            timer_s = timer_r;
        end
    end

    // Repeat timer registers
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            timer_r     <= {TMR_W{1'b0}};
            repeating_r <= 1'b0;
        end else begin
            timer_r     <= timer_s;
            repeating_r <= repeating_s;
        end
    end

    assign rise_s = press_s | repeat_pulse_s;
`else
    assign rise_s = press_s;
`endif

    // FSM state, stability counter and registered outputs
    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_r <= IDLE_LOW;
            count_r <= {CNT_W{1'b0}};
            level_r <= 1'b0;
            rise_r  <= 1'b0;
            fall_r  <= 1'b0;
        end else begin
            state_r <= state_s;
            count_r <= count_s;
            level_r <= level_s;
            rise_r  <= rise_s;
            fall_r  <= fall_s;
        end
    end

    button_debouncer_checker #(
        .PARAMS_OK (PARAMS_OK)
    ) u_checker (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .level   (level_r),
        .rise    (rise_r),
        .fall    (fall_r)
    );
endmodule
